// File: rtl/multi_counter_sum.sv
// multi_counter_sum: NCH parallel SIZE-bit counters with a combinational sum,
// a threshold flag and a shared reload (manual via clr or automatic via threshold).
// Ports:
//   clk        - rising-edge clock for all state
//   rst        - asynchronous active-low reset
//   en         - per-channel count enable
//   init       - per-channel reload values, channel i at [i*SIZE +: SIZE]
//   clr        - synchronous request to reload all channels
//   cnt        - current counter values, packed as for init
//   sum        - full-width sum of all channels
//   over       - sum > THRESH
//   reload     - one-cycle pulse after each reload edge
//   reload_cnt - saturating count of reloads
module multi_counter_sum #(
    parameter int SIZE   = 8,
    parameter int NCH    = 2,
    parameter int THRESH = 9,
    parameter int AUTO   = 1,
    parameter int SAT    = 0,
    localparam int SW    = SIZE + (($clog2(NCH) > 0) ? $clog2(NCH) : 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      en,
    input  logic [NCH*SIZE-1:0] init,
    input  logic                clr,
    output logic [NCH*SIZE-1:0] cnt,
    output logic [SW-1:0]       sum,
    output logic                over,
    output logic                reload,
    output logic [15:0]         reload_cnt
);
    logic [NCH*SIZE-1:0] cnt_q, cnt_d;
    logic [15:0]         rc_q, rc_d;
    logic                reload_q;
    logic                load;
    logic [SIZE-1:0]     cur;
    logic [SW-1:0]       sum_c;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NCH; i++) sum_c = sum_c + SW'(cnt_q[i*SIZE +: SIZE]);
    end

    assign over = sum_c > SW'(THRESH);
    assign load = clr | ((AUTO != 0) & over);

    // Load overrides enable; saturation only blocks the increment out of all-ones.
    always_comb begin
        cnt_d = cnt_q;
        cur   = '0;
        for (int i = 0; i < NCH; i++) begin
            cur = cnt_q[i*SIZE +: SIZE];
            cnt_d[i*SIZE +: SIZE] = load ? init[i*SIZE +: SIZE] :
                                    !en[i] ? cur :
                                    ((SAT != 0) && (&cur)) ? cur : cur + 1'b1;
        end
    end

    assign rc_d = (load && !(&rc_q)) ? rc_q + 16'd1 : rc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            rc_q     <= '0;
            reload_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rc_q     <= rc_d;
            reload_q <= load;
        end
    end

    assign cnt        = cnt_q;
    assign sum        = sum_c;
    assign reload     = reload_q;
    assign reload_cnt = rc_q;
endmodule

// File: tb/tb_multi_counter_sum.sv
// tb_multi_counter_sum: scoreboard bench for the default counter pair plus saturating and wrapping 4-bit single channels.
module tb_multi_counter_sum;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  en = 2'b11;
    logic [15:0] init = 16'h0200;
    logic        clr = 1'b0;
    logic [15:0] cnt;
    logic [8:0]  sum;
    logic        over;
    logic        reload;
    logic [15:0] rc;
    logic [3:0]  cnt_b, cnt_c;
    logic [4:0]  sum_b, sum_c;
    logic        over_b, over_c, rel_b, rel_c;
    logic [15:0] rc_b, rc_c;

    typedef struct {
        logic [15:0] cnt;
        logic [8:0]  sum;
        logic        over;
        logic        rel;
        logic [15:0] rc;
        logic [3:0]  b;
        logic [3:0]  c;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_err = 0;
    int m0 = 0, m1 = 0, mrc = 0, mb = 0, mc = 0, k = 0;
    logic mrel = 1'b0;

    multi_counter_sum dut (
        .clk(clk), .rst(rst), .en(en), .init(init), .clr(clr),
        .cnt(cnt), .sum(sum), .over(over), .reload(reload), .reload_cnt(rc)
    );

    multi_counter_sum #(.SIZE(4), .NCH(1), .AUTO(0), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .en(1'b1), .init(4'd0), .clr(1'b0),
        .cnt(cnt_b), .sum(sum_b), .over(over_b), .reload(rel_b), .reload_cnt(rc_b)
    );

    multi_counter_sum #(.SIZE(4), .NCH(1), .AUTO(0), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .en(1'b1), .init(4'd0), .clr(1'b0),
        .cnt(cnt_c), .sum(sum_c), .over(over_c), .reload(rel_c), .reload_cnt(rc_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge: predict, push, clock, then pop and compare at the next falling edge.
    task automatic step();
        exp_t e;
        logic ld;
        ld = clr || ((m0 + m1) > 9);
        if (ld) begin
            m0 = int'(init[7:0]);
            m1 = int'(init[15:8]);
        end else begin
            if (en[0]) m0 = (m0 + 1) % 256;
            if (en[1]) m1 = (m1 + 1) % 256;
        end
        if (ld && mrc < 65535) mrc++;
        mrel = ld;
        mb = (mb < 15) ? mb + 1 : 15;
        mc = (mc + 1) % 16;
        k++;
        e.cnt  = 16'((m1 << 8) | m0);
        e.sum  = 9'(m0 + m1);
        e.over = (m0 + m1) > 9;
        e.rel  = mrel;
        e.rc   = 16'(mrc);
        e.b    = 4'(mb);
        e.c    = 4'(mc);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = q.pop_front();
        chk("cnt", 32'(cnt), 32'(e.cnt));
        chk("sum", 32'(sum), 32'(e.sum));
        chk("over", 32'(over), 32'(e.over));
        chk("reload", 32'(reload), 32'(e.rel));
        chk("reload_cnt", 32'(rc), 32'(e.rc));
        chk("sat_cnt", 32'(cnt_b), 32'(e.b));
        chk("sat_sum", 32'(sum_b), 32'(e.b));
        chk("sat_over", 32'(over_b), 32'(e.b > 4'd9));
        chk("sat_rel", 32'({rel_b, rc_b}), 32'd0);
        chk("wrap_cnt", 32'(cnt_c), 32'(e.c));
        chk("wrap_sum", 32'(sum_c), 32'(e.c));
        chk("wrap_over", 32'(over_c), 32'(e.c > 4'd9));
        chk("wrap_rel", 32'({rel_c, rc_c}), 32'd0);
    endtask

    // Pulse reset between edges and require every output to clear before the next edge.
    task automatic mid_reset();
        #1 rst = 1'b0;
        #1;
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_reload", 32'(reload), 32'd0);
        chk("rst_rc", 32'(rc), 32'd0);
        chk("rst_b", 32'({cnt_b, rel_b, rc_b}), 32'd0);
        chk("rst_c", 32'({cnt_c, rel_c, rc_c}), 32'd0);
        m0 = 0; m1 = 0; mrc = 0; mrel = 1'b0; mb = 0; mc = 0; k = 0;
        #1 rst = 1'b1;
    endtask

    initial begin
        int sums[11] = '{2, 4, 6, 8, 10, 2, 4, 6, 8, 10, 2};
        int rc0;
        #2;
        chk("init_cnt", 32'(cnt), 32'd0);
        chk("init_sum", 32'(sum), 32'd0);
        chk("init_rc", 32'({reload, rc}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            chk($sformatf("seq_sum%0d", i), 32'(sum), 32'(sums[i]));
            if (i == 5 || i == 10) chk($sformatf("seq_reload%0d", i), 32'({cnt, reload}), {15'd0, 16'h0200, 1'b1});
        end
        chk("seq_rc", 32'(rc), 32'd2);
        en = 2'b01;
        repeat (3) step();
        en = 2'b10;
        step();
        chk("cnt33", 32'(cnt), 32'h0303);
        en = 2'b00;
        for (int i = 0; i < 3; i++) begin
            init = 16'($urandom);
            step();
        end
        chk("init_ignored", 32'(cnt), 32'h0303);
        init = 16'h0401;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_cnt", 32'(cnt), 32'h0401);
        chk("clr_pulse", 32'({reload, rc}), {15'd0, 1'b1, 16'd3});
        step();
        chk("clr_pulse_end", 32'({reload, rc}), {15'd0, 1'b0, 16'd3});
        chk("sat_hold", 32'(cnt_b), 32'd15);
        en = 2'b11;
        repeat (2) step();
        mid_reset();
        step();
        chk("resume", 32'(cnt), 32'h0101);
        init = 16'h0200;
        repeat (4) step();
        chk("pre_both", 32'(over), 32'd1);
        rc0 = int'(rc);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("both_once", 32'(int'(rc) - rc0), 32'd1);
        mid_reset();
        init = 16'h0606;
        clr = 1'b1;
        step();
        clr = 1'b0;
        while (mrc < 16'hFFFE) step();
        chk("rc_fffe", 32'(rc), 32'hFFFE);
        repeat (3) step();
        chk("rc_sat", 32'({reload, rc}), 32'h1FFFF);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
